// File: rtl/ysyx_25040109_lsu_pkg.sv
// rtl/ysyx_25040109_lsu_pkg.sv - shared encodings and FSM state type for the load/store unit
// Purpose: access-size codes, upstream status codes, AXI response codes and the LSU state enum.
// Ports: none (package).
package ysyx_25040109_lsu_pkg;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_ILL = 2'd3;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_BUS      = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;
    localparam logic [1:0] ERR_SIZE     = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_WR,
        S_B,
        S_RESP
    } lsu_state_e;

endpackage

// File: rtl/ysyx_25040109_lsu_ext.sv
// rtl/ysyx_25040109_lsu_ext.sv - byte-lane extract/extend and write-strobe generation
// Purpose: pulls the addressed byte/half/word out of a 32-bit bus word and zero/sign-extends it;
//          the same size/offset pair yields the store byte-enable mask.
// Ports: i_word (bus word), i_off (byte offset), i_size (access size), i_sext (sign-extend),
//        o_data (extended result), o_strb (byte enables shifted to the offset).
module ysyx_25040109_lsu_ext
    import ysyx_25040109_lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    output logic [31:0] o_data,
    output logic [3:0]  o_strb
);

    logic [31:0] w_shift;

    assign w_shift = i_word >> {i_off, 3'b000};

    always_comb begin
        o_data = w_shift;
        o_strb = 4'b0000;
        case (i_size)
            SZ_B: begin
                o_data = {{24{i_sext & w_shift[7]}}, w_shift[7:0]};
                o_strb = 4'b0001 << i_off;
            end
            SZ_H: begin
                o_data = {{16{i_sext & w_shift[15]}}, w_shift[15:0]};
                o_strb = 4'b0011 << i_off;
            end
            SZ_W: begin
                o_data = w_shift;
                o_strb = 4'b1111 << i_off;
            end
            default: begin
                o_data = w_shift;
                o_strb = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25040109_lsu.sv
// rtl/ysyx_25040109_lsu.sv - load/store unit bridging execute-stage requests to the dmem AXI-lite port
// Purpose: one request at a time; size/alignment checks, AR/R or AW/W/B master sequencing,
//          load data extraction, one buffered response with status, saturating OK counters.
// Ports: clk, rst (async active-low); req_* (request handshake and payload);
//        resp_* (response handshake, data, status); dmem_* (AXI-lite-style master channels);
//        load_cnt / store_cnt (retired OK loads / stores).
module ysyx_25040109_lsu
    import ysyx_25040109_lsu_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int CHECK_MISALIGN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic             req_wen,
    input  logic [1:0]       req_size,
    input  logic             req_sext,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic [1:0]       resp_err,
    output logic [31:0]      dmem_araddr,
    output logic             dmem_arvalid,
    input  logic             dmem_arready,
    input  logic [31:0]      dmem_rdata,
    input  logic             dmem_rvalid,
    output logic             dmem_rready,
    input  logic [1:0]       dmem_rresp,
    output logic [31:0]      dmem_awaddr,
    output logic             dmem_awvalid,
    input  logic             dmem_awready,
    output logic [31:0]      dmem_wdata,
    output logic [3:0]       dmem_wstrb,
    output logic             dmem_wen,
    output logic             dmem_wvalid,
    input  logic             dmem_wready,
    input  logic [1:0]       dmem_bresp,
    input  logic             dmem_bvalid,
    output logic             dmem_bready,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    lsu_state_e       r_state;
    lsu_state_e       w_next;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_wen;
    logic [1:0]       r_size;
    logic             r_sext;
    logic             r_aw_done;
    logic             r_w_done;
    logic [31:0]      r_rdata;
    logic [1:0]       r_err;
    logic [CNT_W-1:0] r_load_cnt;
    logic [CNT_W-1:0] r_store_cnt;

    logic             w_req_fire;
    logic             w_misalign;
    logic [1:0]       w_chk_err;
    logic [31:0]      w_ext_data;
    logic [3:0]       w_strb;

    assign req_ready  = (r_state == S_IDLE);
    assign w_req_fire = req_valid && req_ready;

    assign w_misalign = (CHECK_MISALIGN != 0) &&
                        (((req_size == SZ_H) && req_addr[0]) ||
                         ((req_size == SZ_W) && (req_addr[1:0] != 2'b00)));

    // Illegal size outranks misalignment.
    always_comb begin
        w_chk_err = ERR_OK;
        if (req_size == SZ_ILL) begin
            w_chk_err = ERR_SIZE;
        end else if (w_misalign) begin
            w_chk_err = ERR_MISALIGN;
        end
    end

    // Load extraction works on the live R-channel word; the strobe depends only on latched fields.
    ysyx_25040109_lsu_ext u_ext (
        .i_word (dmem_rdata),
        .i_off  (r_addr[1:0]),
        .i_size (r_size),
        .i_sext (r_sext),
        .o_data (w_ext_data),
        .o_strb (w_strb)
    );

    // Every dmem output comes from state or latched registers, never from a dmem input.
    assign dmem_araddr  = r_addr;
    assign dmem_arvalid = (r_state == S_AR);
    assign dmem_rready  = (r_state == S_R);
    assign dmem_awaddr  = r_addr;
    assign dmem_awvalid = (r_state == S_WR) && !r_aw_done;
    assign dmem_wdata   = r_wdata;
    assign dmem_wstrb   = w_strb;
    assign dmem_wen     = (r_state == S_WR);
    assign dmem_wvalid  = (r_state == S_WR) && !r_w_done;
    assign dmem_bready  = (r_state == S_B);
    assign resp_valid   = (r_state == S_RESP);
    assign resp_rdata   = r_rdata;
    assign resp_err     = r_err;
    assign load_cnt     = r_load_cnt;
    assign store_cnt    = r_store_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_fire) begin
                    if (w_chk_err != ERR_OK) begin
                        w_next = S_RESP;
                    end else if (req_wen) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_AR;
                    end
                end
            end
            S_AR:   if (dmem_arready) w_next = S_R;
            S_R:    if (dmem_rvalid) w_next = S_RESP;
            // A channel counts as done if it finished earlier or fires this cycle.
            S_WR:   if ((r_aw_done || dmem_awready) && (r_w_done || dmem_wready)) w_next = S_B;
            S_B:    if (dmem_bvalid) w_next = S_RESP;
            S_RESP: if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wen       <= 1'b0;
            r_size      <= SZ_B;
            r_sext      <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= ERR_OK;
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_fire) begin
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_wen     <= req_wen;
                        r_size    <= req_size;
                        r_sext    <= req_sext;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_rdata   <= 32'd0;
                        r_err     <= w_chk_err;
                    end
                end
                S_R: begin
                    if (dmem_rvalid) begin
                        if (dmem_rresp != RESP_OKAY) begin
                            r_rdata <= 32'd0;
                            r_err   <= ERR_BUS;
                        end else begin
                            r_rdata <= w_ext_data;
                            r_err   <= ERR_OK;
                        end
                    end
                end
                S_WR: begin
                    if (dmem_awready) r_aw_done <= 1'b1;
                    if (dmem_wready)  r_w_done  <= 1'b1;
                end
                S_B: begin
                    if (dmem_bvalid) begin
                        r_rdata <= 32'd0;
                        r_err   <= (dmem_bresp != RESP_OKAY) ? ERR_BUS : ERR_OK;
                    end
                end
                S_RESP: begin
                    if (resp_ready && (r_err == ERR_OK)) begin
                        if (r_wen) begin
                            if (r_store_cnt != CNT_MAX) r_store_cnt <= r_store_cnt + CNT_ONE;
                        end else begin
                            if (r_load_cnt != CNT_MAX) r_load_cnt <= r_load_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_rdata <= r_rdata;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// tb/tb_ysyx_25040109_lsu.sv - self-checking bench for the load/store unit
`timescale 1ns/1ps
module tb_ysyx_25040109_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_sext;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] dmem_araddr;
    logic        dmem_arvalid;
    logic        dmem_arready;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic        dmem_rready;
    logic [1:0]  dmem_rresp;
    logic [31:0] dmem_awaddr;
    logic        dmem_awvalid;
    logic        dmem_awready;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_wen;
    logic        dmem_wvalid;
    logic        dmem_wready;
    logic [1:0]  dmem_bresp;
    logic        dmem_bvalid;
    logic        dmem_bready;
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;

    ysyx_25040109_lsu #(.CNT_W(32), .CHECK_MISALIGN(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wen(req_wen), .req_size(req_size), .req_sext(req_sext),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dmem_araddr(dmem_araddr), .dmem_arvalid(dmem_arvalid), .dmem_arready(dmem_arready),
        .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .dmem_rready(dmem_rready), .dmem_rresp(dmem_rresp),
        .dmem_awaddr(dmem_awaddr), .dmem_awvalid(dmem_awvalid), .dmem_awready(dmem_awready),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_wen(dmem_wen),
        .dmem_wvalid(dmem_wvalid), .dmem_wready(dmem_wready),
        .dmem_bresp(dmem_bresp), .dmem_bvalid(dmem_bvalid), .dmem_bready(dmem_bready),
        .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Slave knobs (written by the stimulus only)
    int          ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0;
    int          pre_seq = 0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    // Slave-owned state and capture
    logic [31:0] mem [0:63];
    bit          mem_inited = 0;
    int          pre_seen = 0;
    int          ar_cnt, aw_cnt, w_cnt, r_wait, b_wait;
    bit          r_pend, aw_got, w_got, b_pend;
    logic [31:0] pend_rdata;
    logic [1:0]  pend_rresp, pend_bresp;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata, sh;
    logic [3:0]  cap_wstrb;
    int          n_ar = 0, n_aw = 0, n_same = 0;
    bit          arf, rf, awf, wf, bf;

    function automatic bit mapped(input logic [31:0] a);
        return a[31:8] == 24'h800000;
    endfunction

    // Memory slave: samples handshakes at the edge, updates its outputs 1ns later.
    always @(posedge clk) begin
        arf = dmem_arvalid && dmem_arready;
        rf  = dmem_rvalid  && dmem_rready;
        awf = dmem_awvalid && dmem_awready;
        wf  = dmem_wvalid  && dmem_wready;
        bf  = dmem_bvalid  && dmem_bready;
        if (rst) begin
            if (arf) begin cap_araddr = dmem_araddr; n_ar++; end
            if (awf) begin cap_awaddr = dmem_awaddr; n_aw++; end
            if (wf)  begin cap_wdata = dmem_wdata; cap_wstrb = dmem_wstrb; end
            if (awf && wf) n_same++;
        end
        #1;
        if (!mem_inited) begin
            for (int i = 0; i < 64; i++) mem[i] = 32'd0;
            mem_inited = 1;
        end
        if (pre_seq != pre_seen) begin
            mem[pre_idx] = pre_val;
            pre_seen = pre_seq;
        end
        if (!rst) begin
            dmem_arready = 0; dmem_rvalid = 0; dmem_rdata = 0; dmem_rresp = 0;
            dmem_awready = 0; dmem_wready = 0; dmem_bvalid = 0; dmem_bresp = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_wait = 0; b_wait = 0;
            r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        end else begin
            if (arf) begin
                dmem_arready = 0; ar_cnt = 0; r_pend = 1; r_wait = r_d;
                if (mapped(cap_araddr)) begin pend_rdata = mem[cap_araddr[7:2]]; pend_rresp = 2'b00; end
                else begin pend_rdata = 32'hBAD0BAD0; pend_rresp = 2'b10; end
            end else if (dmem_arvalid && !dmem_arready) begin
                if (ar_cnt >= ar_d) dmem_arready = 1; else ar_cnt++;
            end
            if (rf) begin
                dmem_rvalid = 0; dmem_rresp = 0;
            end else if (r_pend && !dmem_rvalid) begin
                if (r_wait == 0) begin
                    dmem_rvalid = 1; dmem_rdata = pend_rdata; dmem_rresp = pend_rresp; r_pend = 0;
                end else r_wait--;
            end
            if (awf) begin dmem_awready = 0; aw_cnt = 0; aw_got = 1; end
            else if (dmem_awvalid && !dmem_awready) begin
                if (aw_cnt >= aw_d) dmem_awready = 1; else aw_cnt++;
            end
            if (wf) begin dmem_wready = 0; w_cnt = 0; w_got = 1; end
            else if (dmem_wvalid && !dmem_wready) begin
                if (w_cnt >= w_d) dmem_wready = 1; else w_cnt++;
            end
            if (aw_got && w_got) begin
                // The memory side aligns right-justified store data to the addressed lane.
                if (mapped(cap_awaddr)) begin
                    sh = cap_wdata << {cap_awaddr[1:0], 3'b000};
                    for (int i = 0; i < 4; i++)
                        if (cap_wstrb[i]) mem[cap_awaddr[7:2]][8*i +: 8] = sh[8*i +: 8];
                    pend_bresp = 2'b00;
                end else pend_bresp = 2'b10;
                aw_got = 0; w_got = 0; b_pend = 1; b_wait = b_d;
            end
            if (bf) begin
                dmem_bvalid = 0; dmem_bresp = 0;
            end else if (b_pend && !dmem_bvalid) begin
                if (b_wait == 0) begin dmem_bvalid = 1; dmem_bresp = pend_bresp; b_pend = 0; end
                else b_wait--;
            end
        end
    end

    // Valid-hold monitor: once raised, a valid and its payload stay put until the handshake.
    int          hold_viol = 0, ar_run = 0, ar_last_run = 0;
    logic        prev_arv = 0, prev_awv = 0, prev_wv = 0;
    logic [31:0] prev_ara, prev_awa, prev_wd;
    logic [3:0]  prev_ws;
    always @(negedge clk) begin
        if (!rst) begin
            prev_arv = 0; prev_awv = 0; prev_wv = 0; ar_run = 0;
        end else begin
            if (prev_arv && !arf && (!dmem_arvalid || dmem_araddr != prev_ara)) hold_viol++;
            if (prev_awv && !awf && (!dmem_awvalid || dmem_awaddr != prev_awa)) hold_viol++;
            if (prev_wv && !wf && (!dmem_wvalid || dmem_wdata != prev_wd || dmem_wstrb != prev_ws)) hold_viol++;
            if (dmem_arvalid) ar_run++;
            else if (ar_run != 0) begin ar_last_run = ar_run; ar_run = 0; end
            prev_arv = dmem_arvalid; prev_ara = dmem_araddr;
            prev_awv = dmem_awvalid; prev_awa = dmem_awaddr;
            prev_wv = dmem_wvalid; prev_wd = dmem_wdata; prev_ws = dmem_wstrb;
        end
    end

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] wdata;
        bit          pre;
        logic [31:0] pre_val;
        int          ar_d;
        int          aw_d;
        int          w_d;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_err;
        logic [3:0]  exp_strb;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    vec_t vt[15];
    exp_t sb[$];
    int   ld_model = 0, st_model = 0;

    function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                                input logic sext, input logic [31:0] wdata, input bit pre,
                                input logic [31:0] pv, input int ard, input int awd, input int wd,
                                input logic [31:0] er, input logic [1:0] ee, input logic [3:0] es);
        vec_t v;
        v.wen = wen; v.addr = addr; v.size = size; v.sext = sext; v.wdata = wdata;
        v.pre = pre; v.pre_val = pv; v.ar_d = ard; v.aw_d = awd; v.w_d = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_strb = es;
        return v;
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int   lat;
        int   n_ar0, n_aw0;
        bit   bus;
        exp_t e;
        n_ar0 = n_ar; n_aw0 = n_aw;
        bus = (v.exp_err == 2'd0) || (v.exp_err == 2'd1);
        ar_d = v.ar_d; aw_d = v.aw_d; w_d = v.w_d;
        r_d = $urandom_range(0, 3); b_d = $urandom_range(0, 3);
        if (v.pre) begin
            pre_idx = v.addr[7:2]; pre_val = v.pre_val; pre_seq++;
            @(posedge clk);
        end
        @(negedge clk);
        req_valid = 1; req_addr = v.addr; req_wdata = v.wdata; req_wen = v.wen;
        req_size = v.size; req_sext = v.sext;
        for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
        check($sformatf("v%0d req_ready", id), {31'd0, req_ready}, 32'd1);
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        lat = 1;
        while (!resp_valid && lat < 300) begin @(negedge clk); lat++; end
        check($sformatf("v%0d resp_valid", id), {31'd0, resp_valid}, 32'd1);
        if (!bus) check($sformatf("v%0d err latency", id), lat, 32'd1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        resp_ready = 1;
        e = sb.pop_front();
        check($sformatf("v%0d resp_rdata", id), resp_rdata, e.rdata);
        check($sformatf("v%0d resp_err", id), {30'd0, resp_err}, {30'd0, e.err});
        @(posedge clk);
        @(negedge clk);
        resp_ready = 0;
        if (v.exp_err == 2'd0) begin
            if (v.wen) st_model++; else ld_model++;
        end
        check($sformatf("v%0d load_cnt", id), load_cnt, ld_model);
        check($sformatf("v%0d store_cnt", id), store_cnt, st_model);
        check($sformatf("v%0d ar count", id), n_ar - n_ar0, (!v.wen && bus) ? 1 : 0);
        check($sformatf("v%0d aw count", id), n_aw - n_aw0, (v.wen && bus) ? 1 : 0);
        if (!v.wen && bus) check($sformatf("v%0d araddr", id), cap_araddr, v.addr);
        if (v.wen && bus) begin
            check($sformatf("v%0d awaddr", id), cap_awaddr, v.addr);
            check($sformatf("v%0d wstrb", id), {28'd0, cap_wstrb}, {28'd0, v.exp_strb});
            check($sformatf("v%0d wdata", id), cap_wdata, v.wdata);
        end
    endtask

    initial begin
        int same0;
        rst = 0; req_valid = 0; req_addr = 0; req_wdata = 0; req_wen = 0;
        req_size = 0; req_sext = 0; resp_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_err", {30'd0, resp_err}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset counters", load_cnt | store_cnt, 32'd0);
        check("reset dmem valids", {26'd0, dmem_arvalid, dmem_rready, dmem_awvalid,
                                    dmem_wvalid, dmem_bready, dmem_wen}, 32'd0);
        rst = 1;

        //          wen  addr          sz  sx wdata         pre pre_val       ard awd wd  exp_rdata     err  strb
        vt[0]  = mk(0, 32'h80000003, 2'd0, 1, 32'h0,        1, 32'h80FF1234, 0,  0,  0,  32'hFFFFFF80, 2'd0, 4'h0);
        vt[1]  = mk(0, 32'h80000002, 2'd1, 0, 32'h0,        1, 32'hBEEF1234, 5,  0,  0,  32'h0000BEEF, 2'd0, 4'h0);
        vt[2]  = mk(1, 32'h80000001, 2'd0, 0, 32'h000000AB, 1, 32'h11223344, 0,  2,  2,  32'h0,        2'd0, 4'b0010);
        vt[3]  = mk(0, 32'h80000001, 2'd0, 0, 32'h0,        0, 32'h0,        1,  0,  0,  32'h000000AB, 2'd0, 4'h0);
        vt[4]  = mk(0, 32'h80000002, 2'd2, 0, 32'h0,        0, 32'h0,        0,  0,  0,  32'h0,        2'd2, 4'h0);
        vt[5]  = mk(0, 32'h80000000, 2'd3, 0, 32'h0,        0, 32'h0,        0,  0,  0,  32'h0,        2'd3, 4'h0);
        vt[6]  = mk(0, 32'h90000000, 2'd2, 0, 32'h0,        0, 32'h0,        2,  0,  0,  32'h0,        2'd1, 4'h0);
        vt[7]  = mk(1, 32'h80000012, 2'd1, 0, 32'h0000CAFE, 1, 32'h0,        0,  3,  0,  32'h0,        2'd0, 4'b1100);
        vt[8]  = mk(0, 32'h80000012, 2'd1, 1, 32'h0,        0, 32'h0,        0,  0,  0,  32'hFFFFCAFE, 2'd0, 4'h0);
        vt[9]  = mk(1, 32'h80000020, 2'd2, 0, 32'hDEADBEEF, 0, 32'h0,        0,  0,  4,  32'h0,        2'd0, 4'b1111);
        vt[10] = mk(0, 32'h80000020, 2'd2, 0, 32'h0,        0, 32'h0,        3,  0,  0,  32'hDEADBEEF, 2'd0, 4'h0);
        vt[11] = mk(0, 32'h80000021, 2'd0, 1, 32'h0,        0, 32'h0,        0,  0,  0,  32'hFFFFFFBE, 2'd0, 4'h0);
        vt[12] = mk(1, 32'h80000011, 2'd1, 0, 32'h00001234, 0, 32'h0,        0,  0,  0,  32'h0,        2'd2, 4'h0);
        vt[13] = mk(1, 32'h90000000, 2'd2, 0, 32'h12345678, 0, 32'h0,        0,  1,  2,  32'h0,        2'd1, 4'b1111);
        vt[14] = mk(0, 32'h80000003, 2'd0, 0, 32'h0,        0, 32'h0,        0,  0,  0,  32'h00000011, 2'd0, 4'h0);

        for (int i = 0; i < 15; i++) begin
            same0 = n_same;
            run_vec(i, vt[i]);
            if (i == 1) check("v1 arready stall length", {31'd0, ar_last_run >= 5}, 32'd1);
            if (i == 2) check("v2 aw/w same-cycle fire", n_same - same0, 32'd1);
        end

        // Reset while waiting for B with nobody consuming responses.
        aw_d = 0; w_d = 0; b_d = 30;
        @(negedge clk);
        req_valid = 1; req_addr = 32'h80000030; req_wdata = 32'h55; req_wen = 1;
        req_size = 2'd2; req_sext = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        for (int k = 0; k < 100 && !dmem_bready; k++) @(negedge clk);
        check("rst seq reached B", {31'd0, dmem_bready}, 32'd1);
        #2 rst = 0;
        #1;
        check("rst seq valids dropped", {26'd0, dmem_arvalid, dmem_rready, dmem_awvalid,
                                         dmem_wvalid, dmem_bready, resp_valid}, 32'd0);
        check("rst seq counters", load_cnt | store_cnt, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1;
        ld_model = 0; st_model = 0;
        @(negedge clk);
        check("rst seq req_ready", {31'd0, req_ready}, 32'd1);
        run_vec(15, mk(0, 32'h80000000, 2'd2, 0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h1122AB44, 2'd0, 4'h0));

        check("valid hold violations", hold_viol, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
